// File: rtl/regfile_rsp.sv
// -----------------------------------------------------------------------------
// regfile_rsp
//
// General-purpose register file acting as the responder for the decode stage's
// two operand-read ports, plus the single write-back port from the last
// pipeline stage.
//
// Features:
//   - Two combinational read ports with same-cycle write-through bypass.
//   - Register $0 is hardwired to read zero; write-backs to it are dropped.
//   - After every reset a hardware sequencer clears all NUM_REGS entries, one
//     per clock. The pipeline is held (stallreq_o=1) until the clear is done.
//
// Ports:
//   clk, rst          single rising-edge clock, synchronous active-high reset
//   we/waddr/wdata    write-back port (ignored while clearing)
//   re1/raddr1/rdata1 operand read port 1 (rdata1 is combinational)
//   re2/raddr2/rdata2 operand read port 2 (rdata2 is combinational)
//   ready_o           registered, high once the clear sequence has completed
//   stallreq_o        ~ready_o, pipeline hold request
//
// NUM_REGS must equal 2**ADDR_W so the clear counter visits every entry and
// wraps back to zero.
// -----------------------------------------------------------------------------
module regfile_rsp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic              ready_o,
  output logic              stallreq_o
);

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] ZERO_DATA = {DATA_W{1'b0}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              ready_q, ready_d;

  // Storage is deliberately not reset: the clear sequencer owns initialisation,
  // and the read path masks everything until ready_q is set.
  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Single storage write port shared by the clear sequencer and write-back.
  logic              wr_en_s;
  logic [ADDR_W-1:0] wr_addr_s;
  logic [DATA_W-1:0] wr_data_s;

  logic              rd_valid_s;

  // Read-port priority mux: masked before ready / during reset, $0 reads zero,
  // a matching write-back is forwarded, otherwise storage is returned if enabled.
  function automatic logic [DATA_W-1:0] read_port(
    input logic              valid,
    input logic              re,
    input logic [ADDR_W-1:0] raddr,
    input logic              wr_we,
    input logic [ADDR_W-1:0] wr_addr,
    input logic [DATA_W-1:0] wr_data,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] result;
    if (!valid) begin
      result = ZERO_DATA;
    end else if (raddr == ZERO_ADDR) begin
      result = ZERO_DATA;
    end else if (re && wr_we && (wr_addr == raddr)) begin
      result = wr_data;
    end else if (re) begin
      result = stored;
    end else begin
      result = ZERO_DATA;
    end
    return result;
  endfunction

  // Next-state logic for the clear/ready FSM and selection of the storage write.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    ready_d   = ready_q;
    wr_en_s   = 1'b0;
    wr_addr_s = clr_cnt_q;
    wr_data_s = ZERO_DATA;

    if (rst) begin
      // Storage is left untouched in a reset cycle; the restart is applied
      // by the state register.
      state_d   = ST_CLEAR;
      clr_cnt_d = ZERO_ADDR;
      ready_d   = 1'b0;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          // One entry per clock; write-backs are dropped, not queued.
          wr_en_s   = 1'b1;
          wr_addr_s = clr_cnt_q;
          wr_data_s = ZERO_DATA;
          clr_cnt_d = clr_cnt_q + ONE_ADDR;
          if (clr_cnt_q == LAST_IDX) begin
            state_d = ST_READY;
            ready_d = 1'b1;
          end else begin
            state_d = ST_CLEAR;
            ready_d = 1'b0;
          end
        end
        ST_READY: begin
          ready_d = 1'b1;
          if (we && (waddr != ZERO_ADDR)) begin
            wr_en_s   = 1'b1;
            wr_addr_s = waddr;
            wr_data_s = wdata;
          end else begin
            wr_en_s   = 1'b0;
          end
        end
        default: begin
          state_d   = ST_CLEAR;
          clr_cnt_d = ZERO_ADDR;
          ready_d   = 1'b0;
        end
      endcase
    end
  end

  // FSM state, clear counter and ready flag with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= ZERO_ADDR;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      ready_q   <= ready_d;
    end
  end

  // Register storage update (clear sequencer or write-back).
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      regs_q[wr_addr_s] <= wr_data_s;
    end
  end

  // Read gating: nothing from storage is visible in reset or before the clear ends.
  always_comb begin
    rd_valid_s = 1'b0;
    if (!rst && ready_q) begin
      rd_valid_s = 1'b1;
    end else begin
      rd_valid_s = 1'b0;
    end
  end

  // Operand read port 1.
  always_comb begin
    rdata1 = ZERO_DATA;
    rdata1 = read_port(rd_valid_s, re1, raddr1, we, waddr, wdata, regs_q[raddr1]);
  end

  // Operand read port 2.
  always_comb begin
    rdata2 = ZERO_DATA;
    rdata2 = read_port(rd_valid_s, re2, raddr2, we, waddr, wdata, regs_q[raddr2]);
  end

  // Handshake outputs come straight from the ready flop.
  always_comb begin
    ready_o    = ready_q;
    stallreq_o = ~ready_q;
  end

endmodule

// File: tb/tb_regfile_rsp.sv
// -----------------------------------------------------------------------------
// tb_regfile_rsp
//
// Directed self-checking bench for regfile_rsp. Expected values are pushed to
// a scoreboard queue when each stimulus step is driven and popped against the
// DUT outputs a few time units later, away from the clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_rsp;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic          re1;
  logic [AW-1:0] raddr1;
  logic [DW-1:0] rdata1;
  logic          re2;
  logic [AW-1:0] raddr2;
  logic [DW-1:0] rdata2;
  logic          ready_o;
  logic          stallreq_o;

  int vectors;
  int miscompares;

  string         tag_q[$];
  logic [DW-1:0] exp_q[$];

  regfile_rsp #(
    .DATA_W  (DW),
    .ADDR_W  (AW),
    .NUM_REGS(32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .re1       (re1),
    .raddr1    (raddr1),
    .rdata1    (rdata1),
    .re2       (re2),
    .raddr2    (raddr2),
    .rdata2    (rdata2),
    .ready_o   (ready_o),
    .stallreq_o(stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w_en, input logic [AW-1:0] w_a, input logic [DW-1:0] w_d,
                       input logic r1_en, input logic [AW-1:0] r1_a,
                       input logic r2_en, input logic [AW-1:0] r2_a);
    we     = w_en;
    waddr  = w_a;
    wdata  = w_d;
    re1    = r1_en;
    raddr1 = r1_a;
    re2    = r2_en;
    raddr2 = r2_a;
  endtask

  task automatic push_exp(input string tag, input logic [DW-1:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic pop_check(input logic [DW-1:0] observed);
    string         tag;
    logic [DW-1:0] expected;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0x%08h required an entry", observed);
    end else begin
      tag      = tag_q.pop_front();
      expected = exp_q.pop_front();
      assert (observed === expected) else begin
        miscompares++;
        $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
    end
  endtask

  // Queue expectations for all outputs, let them settle, then compare.
  task automatic sample(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                        input logic e_rdy);
    push_exp({tag, ".rdata1"}, e1);
    push_exp({tag, ".rdata2"}, e2);
    push_exp({tag, ".ready"},  {31'd0, e_rdy});
    push_exp({tag, ".stall"},  {31'd0, ~e_rdy});
    #3;
    pop_check(rdata1);
    pop_check(rdata2);
    pop_check({31'd0, ready_o});
    pop_check({31'd0, stallreq_o});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);

    // Two reset cycles, then release and watch the 32-cycle clear.
    tick();
    sample("reset1", 32'd0, 32'd0, 1'b0);
    tick();
    sample("reset2", 32'd0, 32'd0, 1'b0);
    rst = 1'b0;
    sample("rst_release", 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      if (k == 2) begin
        drive(1'b1, 5'd31, 32'hA5A5_A5A5, 1'b1, 5'd5, 1'b1, 5'd5);
      end else if (k == 10) begin
        drive(1'b1, 5'd3, 32'h0BAD_F00D, 1'b1, 5'd5, 1'b1, 5'd5);
      end else begin
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b1, 5'd5);
      end
      sample($sformatf("clear_%0d", k), 32'd0, 32'd0, (k == 32));
    end

    // Writes issued during the clear were dropped.
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b1, 5'd3);
    sample("clr_write_drop", 32'd0, 32'd0, 1'b1);

    // Basic write then read; a write with re=0 returns zero.
    tick();
    drive(1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0, 5'd7, 1'b0, 5'd7);
    sample("wr_r7_re0", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd7);
    sample("rd_r7", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd7, 1'b1, 5'd7);
    sample("rd_r7_re1_off", 32'd0, 32'hDEAD_BEEF, 1'b1);

    // Bypass: r9 holds 1, same-cycle write of a new value to both ports.
    tick();
    drive(1'b1, 5'd9, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
    sample("wr_r9_init", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);
    sample("rd_r9_old", 32'h0000_0001, 32'h0000_0001, 1'b1);
    tick();
    drive(1'b1, 5'd9, 32'h1234_5678, 1'b1, 5'd9, 1'b1, 5'd9);
    sample("bypass_r9", 32'h1234_5678, 32'h1234_5678, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 5'd9);
    sample("rd_r9_new", 32'h1234_5678, 32'h1234_5678, 1'b1);

    // Bypass is per port: port1 disabled on matching address, port2 elsewhere.
    tick();
    drive(1'b1, 5'd10, 32'hCAFE_0010, 1'b0, 5'd10, 1'b1, 5'd7);
    sample("bypass_port_sel", 32'd0, 32'hDEAD_BEEF, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd10);
    sample("rd_r7_r10", 32'hDEAD_BEEF, 32'hCAFE_0010, 1'b1);

    // $0 protection, including a same-cycle bypass attempt.
    tick();
    drive(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b1, 5'd0);
    sample("r0_bypass", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    sample("r0_read", 32'd0, 32'd0, 1'b1);

    // Reset mid-operation: r4 written, then one reset cycle.
    tick();
    drive(1'b1, 5'd4, 32'h0000_0055, 1'b0, 5'd0, 1'b0, 5'd0);
    sample("wr_r4", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd7);
    sample("rd_r4", 32'h0000_0055, 32'hDEAD_BEEF, 1'b1);
    tick();
    rst = 1'b1;
    sample("rst_mid_comb", 32'd0, 32'd0, 1'b1);
    tick();
    rst = 1'b0;
    sample("rst_mid_edge", 32'd0, 32'd0, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      tick();
      sample($sformatf("reclear_%0d", k), 32'd0, 32'd0, (k == 32));
    end
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd9);
    sample("rd_r4_after_rst", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 5'd10);
    sample("rd_r7_after_rst", 32'd0, 32'd0, 1'b1);

    // Storage is writable again after the re-clear.
    tick();
    drive(1'b1, 5'd31, 32'h8000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
    sample("wr_r31", 32'd0, 32'd0, 1'b1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b1, 5'd31);
    sample("rd_r31", 32'h8000_0001, 32'h8000_0001, 1'b1);

    if (exp_q.size() != 0) begin
      miscompares++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
